// File: rtl/zero_extend_unit.sv
// Load-data extension unit: turns a byte-wide memory read into a 16-bit register-file value.
// It has a same-cycle zero-extend path and a registered, mode-selectable path with flags.
module zero_extend_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  lowerByteInput,
    input  logic [7:0]  upperByteInput,
    input  logic        byteSelect,
    input  logic [1:0]  extendMode,
    input  logic        extendValid,
    output logic [15:0] zeroExtendedResult,
    output logic [15:0] extendedResultReg,
    output logic        resultValid,
    output logic        resultZero,
    output logic        resultNegative
);

    localparam logic [1:0] MODE_ZERO = 2'b00;
    localparam logic [1:0] MODE_SIGN = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    logic [7:0]  sourceByte_s;
    logic [15:0] nextResult_s;

    // Extension rule shared by the registered path; the reserved mode yields zero.
    function automatic logic [15:0] extendByte(
        input logic [1:0]  mode,
        input logic [7:0]  srcByte,
        input logic [15:0] fullWord
    );
        logic [15:0] res;
        case (mode)
            MODE_ZERO: res = {8'h00, srcByte};
            MODE_SIGN: res = {{8{srcByte[7]}}, srcByte};
            MODE_WORD: res = fullWord;
            default:   res = 16'h0000;
        endcase
        return res;
    endfunction

    assign zeroExtendedResult = {8'h00, lowerByteInput};

    // Select the source byte and form the next registered result.
    always_comb begin
        sourceByte_s = lowerByteInput;
        if (byteSelect == 1'b1) begin
            sourceByte_s = upperByteInput;
        end else begin
            sourceByte_s = lowerByteInput;
        end
        nextResult_s = extendByte(extendMode, sourceByte_s, {upperByteInput, lowerByteInput});
    end

    // Capture requests; reset wins over a coincident request, flags follow the stored value.
    always_ff @(posedge clk) begin
        if (reset) begin
            extendedResultReg <= 16'h0000;
            resultValid       <= 1'b0;
            resultZero        <= 1'b1;
            resultNegative    <= 1'b0;
        end else if (extendValid) begin
            extendedResultReg <= nextResult_s;
            resultValid       <= 1'b1;
            resultZero        <= (nextResult_s == 16'h0000);
            resultNegative    <= nextResult_s[15];
        end else begin
            resultValid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zero_extend_unit.sv
// Directed bench for zero_extend_unit with hand-computed expected values.
module tb_zero_extend_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  lowerByteInput;
    logic [7:0]  upperByteInput;
    logic        byteSelect;
    logic [1:0]  extendMode;
    logic        extendValid;
    logic [15:0] zeroExtendedResult;
    logic [15:0] extendedResultReg;
    logic        resultValid;
    logic        resultZero;
    logic        resultNegative;

    int total = 0;
    int bad   = 0;
    logic [15:0] wideValue;

    zero_extend_unit dut (
        .clk                (clk),
        .reset              (reset),
        .lowerByteInput     (lowerByteInput),
        .upperByteInput     (upperByteInput),
        .byteSelect         (byteSelect),
        .extendMode         (extendMode),
        .extendValid        (extendValid),
        .zeroExtendedResult (zeroExtendedResult),
        .extendedResultReg  (extendedResultReg),
        .resultValid        (resultValid),
        .resultZero         (resultZero),
        .resultNegative     (resultNegative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs, then sample just after the capturing edge.
    task automatic step(input logic [1:0] mode, input logic sel, input logic [7:0] up,
                        input logic [7:0] lo, input logic vld);
        extendMode     = mode;
        byteSelect     = sel;
        upperByteInput = up;
        lowerByteInput = lo;
        extendValid    = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic [15:0] res, input logic vld,
                              input logic zro, input logic neg);
        checkVal({tag, ".res"},  extendedResultReg, res);
        checkVal({tag, ".vld"},  {15'h0000, resultValid}, {15'h0000, vld});
        checkVal({tag, ".zero"}, {15'h0000, resultZero}, {15'h0000, zro});
        checkVal({tag, ".neg"},  {15'h0000, resultNegative}, {15'h0000, neg});
    endtask

    initial begin
        reset          = 1'b1;
        extendValid    = 1'b0;
        extendMode     = 2'b00;
        byteSelect     = 1'b0;
        upperByteInput = 8'h00;
        lowerByteInput = 8'hFF;

        // Combinational sweep
        #15 checkVal("comb_ff", zeroExtendedResult, 16'h00FF);
        lowerByteInput = 8'h21;
        #15 checkVal("comb_21", zeroExtendedResult, 16'h0021);
        lowerByteInput = 8'h98;
        #15 checkVal("comb_98", zeroExtendedResult, 16'h0098);
        wideValue = 16'hF0FF;
        lowerByteInput = wideValue[7:0];
        #15 checkVal("comb_trunc", zeroExtendedResult, 16'h00FF);

        // Reset state
        step(2'b00, 1'b0, 8'h00, 8'h00, 1'b0);
        checkFlags("reset", 16'h0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;

        // Sign extension
        step(2'b01, 1'b0, 8'h00, 8'h98, 1'b1);
        checkFlags("sext_98", 16'hFF98, 1'b1, 1'b0, 1'b1);
        step(2'b01, 1'b0, 8'h00, 8'h21, 1'b1);
        checkFlags("sext_21", 16'h0021, 1'b1, 1'b0, 1'b0);

        // Byte select and word mode
        step(2'b00, 1'b1, 8'hA5, 8'h3C, 1'b1);
        checkFlags("zext_up", 16'h00A5, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 8'hA5, 8'h3C, 1'b1);
        checkFlags("sext_up", 16'hFFA5, 1'b1, 1'b0, 1'b1);
        step(2'b10, 1'b1, 8'hA5, 8'h3C, 1'b1);
        checkFlags("word", 16'hA53C, 1'b1, 1'b0, 1'b1);
        step(2'b11, 1'b0, 8'hA5, 8'h3C, 1'b1);
        checkFlags("reserved", 16'h0000, 1'b1, 1'b1, 1'b0);

        // Single request then idle: value holds while inputs change
        step(2'b00, 1'b0, 8'hA5, 8'h77, 1'b1);
        checkFlags("hs_req", 16'h0077, 1'b1, 1'b0, 1'b0);
        step(2'b10, 1'b0, 8'hFF, 8'hFF, 1'b0);
        checkFlags("hs_idle", 16'h0077, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b0, 8'hFF, 8'hFF, 1'b0);
        checkFlags("hs_idle2", 16'h0077, 1'b0, 1'b0, 1'b0);

        // Three back-to-back requests
        step(2'b10, 1'b0, 8'h12, 8'h34, 1'b1);
        checkFlags("b2b_1", 16'h1234, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 8'h80, 8'h34, 1'b1);
        checkFlags("b2b_2", 16'hFF80, 1'b1, 1'b0, 1'b1);
        step(2'b00, 1'b0, 8'h80, 8'h00, 1'b1);
        checkFlags("b2b_3", 16'h0000, 1'b1, 1'b1, 1'b0);

        // Reset mid-operation drops the coincident request
        step(2'b10, 1'b0, 8'h12, 8'h34, 1'b1);
        checkFlags("pre_rst", 16'h1234, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step(2'b01, 1'b0, 8'h00, 8'hFF, 1'b1);
        checkFlags("mid_rst", 16'h0000, 1'b0, 1'b1, 1'b0);
        lowerByteInput = 8'h5A;
        #1 checkVal("comb_rst", zeroExtendedResult, 16'h005A);
        reset = 1'b0;
        step(2'b00, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
